// File: rtl/cordic_hyp_ext_rot.sv
// Iterative rotation-mode range extension for the hyperbolic CORDIC (indices -(M-1)..0).
// Define CORDIC_HYP_EXT_ROT_SAT_EN for saturating x/y arithmetic; z always wraps.
module cordic_hyp_ext_rot #(
    parameter int WD = 32,
    parameter int M  = 6
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2*WD-1:0]   i_x,
    input  logic [2*WD-1:0]   i_y,
    input  logic [31:0]       i_z,
    output logic [2*WD-1:0]   o_x,
    output logic [2*WD-1:0]   o_y,
    output logic [31:0]       o_z,
    output logic              o_valid,
    input  logic              i_ready
);
    localparam int W = 2 * WD;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic signed [W-1:0] r_x;
    logic signed [W-1:0] r_y;
    logic signed [31:0]  r_z;
    logic signed [3:0]   r_k;
    logic [3:0]          w_nk;
    logic [3:0]          w_sh;
    logic signed [31:0]  w_atanh;
    logic                w_dneg;
    logic signed [W-1:0] w_tx;
    logic signed [W-1:0] w_ty;
    logic signed [W-1:0] w_xn;
    logic signed [W-1:0] w_yn;
    logic signed [31:0]  w_zn;

    // a + b (sub=0) or a - b (sub=1); optional one-guard-bit saturation
    function automatic logic signed [W-1:0] f_acc(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b,
                                                  input logic sub);
`ifdef CORDIC_HYP_EXT_ROT_SAT_EN
        logic [W:0] s;
        s = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
        if (s[W] != s[W-1])
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return s[W-1:0];
`else
        return sub ? (a - b) : (a + b);
`endif
    endfunction

    assign w_nk = $unsigned(-r_k);
    assign w_sh = w_nk + 4'd2;

    always_comb begin
        w_atanh = '0;
        case (w_nk)
            4'd5:    w_atanh = 32'sh02C54820;
            4'd4:    w_atanh = 32'sh026C0E53;
            4'd3:    w_atanh = 32'sh0212523D;
            4'd2:    w_atanh = 32'sh01B78CD5;
            4'd1:    w_atanh = 32'sh015AA163;
            4'd0:    w_atanh = 32'sh00F91395;
            default: w_atanh = '0;
        endcase
    end

    assign w_dneg = r_z[31];
    assign w_tx   = r_x - (r_x >>> w_sh);
    assign w_ty   = r_y - (r_y >>> w_sh);
    assign w_xn   = f_acc(r_x, w_ty, w_dneg);
    assign w_yn   = f_acc(r_y, w_tx, w_dneg);
    assign w_zn   = w_dneg ? (r_z + w_atanh) : (r_z - w_atanh);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_valid) w_state_nxt = S_ITER;
            S_ITER:  if (r_k == 4'sd0) w_state_nxt = S_DONE;
            S_DONE:  if (i_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
            r_k <= '0;
        end else if (r_state == S_IDLE && i_valid) begin
            r_x <= i_x;
            r_y <= i_y;
            r_z <= i_z;
            r_k <= 4'(1 - M);
        end else if (r_state == S_ITER) begin
            r_x <= w_xn;
            r_y <= w_yn;
            r_z <= w_zn;
            if (r_k != 4'sd0) r_k <= r_k + 4'sd1;
        end
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_valid = (r_state == S_DONE);
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_z     = r_z;
endmodule

// File: tb/tb_cordic_hyp_ext_rot.sv
// Bench for cordic_hyp_ext_rot: one M=1 and one M=6 instance checked against a wide-integer model.
module tb_cordic_hyp_ext_rot;
    logic        clk = 1'b0;
    logic        arst;
    logic        in_valid [2];
    logic        in_ready [2];
    logic [63:0] in_x [2];
    logic [63:0] in_y [2];
    logic [31:0] in_z [2];
    logic        out_ready [2];
    logic        out_valid [2];
    logic [63:0] out_x [2];
    logic [63:0] out_y [2];
    logic [31:0] out_z [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cordic_hyp_ext_rot #(.WD(32), .M(1)) u_m1 (
        .i_clk(clk), .i_arst(arst), .i_valid(in_valid[0]), .o_ready(out_ready[0]),
        .i_x(in_x[0]), .i_y(in_y[0]), .i_z(in_z[0]),
        .o_x(out_x[0]), .o_y(out_y[0]), .o_z(out_z[0]),
        .o_valid(out_valid[0]), .i_ready(in_ready[0]));

    cordic_hyp_ext_rot #(.WD(32), .M(6)) u_m6 (
        .i_clk(clk), .i_arst(arst), .i_valid(in_valid[1]), .o_ready(out_ready[1]),
        .i_x(in_x[1]), .i_y(in_y[1]), .i_z(in_z[1]),
        .o_x(out_x[1]), .o_y(out_y[1]), .o_z(out_z[1]),
        .o_valid(out_valid[1]), .i_ready(in_ready[1]));

    function automatic logic signed [31:0] atanh_q(input int k);
        case (k)
            -5: return 32'sh02C54820;
            -4: return 32'sh026C0E53;
            -3: return 32'sh0212523D;
            -2: return 32'sh01B78CD5;
            -1: return 32'sh015AA163;
            default: return 32'sh00F91395;
        endcase
    endfunction

    function automatic logic signed [127:0] fit64(input logic signed [127:0] v);
        logic [63:0] t;
`ifdef CORDIC_HYP_EXT_ROT_SAT_EN
        if (v > 128'sh7FFFFFFFFFFFFFFF) return 128'sh7FFFFFFFFFFFFFFF;
        if (v < -128'sh8000000000000000) return -128'sh8000000000000000;
        return v;
`else
        t = v[63:0];
        return $signed(t);
`endif
    endfunction

    // exact-integer model: x,y in 128 bits, fitted back to 64 bits after every step
    task automatic model(input int m, input logic [63:0] xi, yi, input logic [31:0] zi,
                         output logic [63:0] xo, yo, output logic [31:0] zo);
        logic signed [127:0] x, y, tx, ty;
        logic signed [31:0]  z;
        x = $signed(xi);
        y = $signed(yi);
        z = $signed(zi);
        for (int k = -(m - 1); k <= 0; k++) begin
            tx = x - (x >>> (2 - k));
            ty = y - (y >>> (2 - k));
            if (z >= 0) begin
                x = fit64(x + ty);
                y = fit64(y + tx);
                z = z - atanh_q(k);
            end else begin
                x = fit64(x - ty);
                y = fit64(y - tx);
                z = z + atanh_q(k);
            end
        end
        xo = x[63:0];
        yo = y[63:0];
        zo = z;
    endtask

    // drive one sample into instance s and wait (bounded) for its result
    task automatic op(input int s, input logic [63:0] x, y, input logic [31:0] z,
                      output logic [63:0] ox, oy, output logic [31:0] oz,
                      output int lat, output int rlow);
        @(negedge clk);
        in_x[s] = x;
        in_y[s] = y;
        in_z[s] = z;
        in_valid[s] = 1'b1;
        @(posedge clk);
        #1 in_valid[s] = 1'b0;
        lat = 0;
        rlow = 0;
        forever begin
            @(negedge clk);
            if (!out_ready[s]) rlow++;
            if (out_valid[s] || lat >= 40) break;
            @(posedge clk);
            lat++;
        end
        ox = out_x[s];
        oy = out_y[s];
        oz = out_z[s];
    endtask

    task automatic test_reset;
        for (int s = 0; s < 2; s++) begin
            n_tests++;
            if (out_x[s] !== 64'd0 || out_y[s] !== 64'd0 || out_z[s] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_data[%0d] got x=%h y=%h z=%h want zeros", s, out_x[s], out_y[s], out_z[s]);
            end
            n_tests++;
            if (out_valid[s] !== 1'b0 || out_ready[s] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hs[%0d] got valid=%b ready=%b want 0/1", s, out_valid[s], out_ready[s]);
            end
        end
    endtask

    task automatic test_positive_z;
        logic [63:0] ox, oy;
        logic [31:0] oz;
        int lat, rl;
        op(0, 64'h00000001_00000000, 64'd0, 32'h01000000, ox, oy, oz, lat, rl);
        n_tests++;
        if (ox !== 64'h00000001_00000000 || oy !== 64'h00000000_C0000000 || oz !== 32'h0006EC6B) begin
            n_fail++;
            $display("FAIL pos_z got x=%h y=%h z=%h want 0000000100000000 00000000c0000000 0006ec6b", ox, oy, oz);
        end
        n_tests++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL pos_z_latency got %0d want 1", lat);
        end
    endtask

    task automatic test_negative_z;
        logic [63:0] ox, oy;
        logic [31:0] oz;
        int lat, rl;
        op(0, 64'h00000001_00000000, 64'd0, 32'hFF000000, ox, oy, oz, lat, rl);
        n_tests++;
        if (ox !== 64'h00000001_00000000 || oy !== 64'hFFFFFFFF_40000000 || oz !== 32'hFFF91395) begin
            n_fail++;
            $display("FAIL neg_z got x=%h y=%h z=%h want 0000000100000000 ffffffff40000000 fff91395", ox, oy, oz);
        end
    endtask

    task automatic test_latency_rom;
        logic [63:0] x, y, ox, oy, ex, ey;
        logic [31:0] oz, ez;
        int lat, rl;
        x = {32'd0, $urandom};
        y = {32'd0, $urandom} >> 4;
        model(6, x, y, 32'd0, ex, ey, ez);
        op(1, x, y, 32'd0, ox, oy, oz, lat, rl);
        n_tests++;
        if (lat !== 6) begin
            n_fail++;
            $display("FAIL m6_latency got %0d want 6", lat);
        end
        n_tests++;
        if (rl !== 7) begin
            n_fail++;
            $display("FAIL m6_ready_low got %0d cycles want 7", rl);
        end
        n_tests++;
        if (ox !== ex || oy !== ey || oz !== ez) begin
            n_fail++;
            $display("FAIL m6_z0 got x=%h y=%h z=%h want x=%h y=%h z=%h", ox, oy, oz, ex, ey, ez);
        end
        @(negedge clk);
        n_tests++;
        if (out_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL m6_release got ready=%b valid=%b want 1/0", out_ready[1], out_valid[1]);
        end
    endtask

    task automatic test_random;
        logic [63:0] x, y, ox, oy, ex, ey;
        logic [31:0] z, oz, ez;
        int lat, rl;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 12; i++) begin
                x = {$urandom, $urandom};
                y = {$urandom, $urandom};
                z = $urandom;
                if (i < 6) begin
                    x = $signed(x) >>> 3;
                    y = $signed(y) >>> 5;
                end
                model(s == 0 ? 1 : 6, x, y, z, ex, ey, ez);
                op(s, x, y, z, ox, oy, oz, lat, rl);
                n_tests++;
                if (ox !== ex || oy !== ey || oz !== ez || lat !== (s == 0 ? 1 : 6)) begin
                    n_fail++;
                    $display("FAIL random[%0d.%0d] got x=%h y=%h z=%h lat=%0d want x=%h y=%h z=%h",
                             s, i, ox, oy, oz, lat, ex, ey, ez);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] x, y, ox, oy, ex, ey;
        logic [31:0] z, oz, ez;
        int lat, rl;
        bit bad;
        in_ready[1] = 1'b0;
        op(1, {$urandom, $urandom} >>> 2, {$urandom, $urandom} >>> 6, $urandom, ox, oy, oz, lat, rl);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid[1] = $urandom_range(0, 1);
            in_x[1] = {$urandom, $urandom};
            in_y[1] = {$urandom, $urandom};
            in_z[1] = $urandom;
            @(negedge clk);
            if (out_x[1] !== ox || out_y[1] !== oy || out_z[1] !== oz ||
                out_ready[1] !== 1'b0 || out_valid[1] !== 1'b1) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL backpressure_hold got x=%h y=%h z=%h rdy=%b vld=%b want x=%h y=%h z=%h rdy=0 vld=1",
                     out_x[1], out_y[1], out_z[1], out_ready[1], out_valid[1], ox, oy, oz);
        end
        in_valid[1] = 1'b0;
        in_ready[1] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid[1] !== 1'b0 || out_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_consume got valid=%b ready=%b want 0/1", out_valid[1], out_ready[1]);
        end
        x = {$urandom, $urandom} >>> 3;
        y = {$urandom, $urandom} >>> 3;
        z = $urandom;
        model(6, x, y, z, ex, ey, ez);
        op(1, x, y, z, ox, oy, oz, lat, rl);
        n_tests++;
        if (ox !== ex || oy !== ey || oz !== ez) begin
            n_fail++;
            $display("FAIL backpressure_next got x=%h y=%h z=%h want x=%h y=%h z=%h", ox, oy, oz, ex, ey, ez);
        end
    endtask

    task automatic test_reset_mid_iter;
        logic [63:0] x, y, ox, oy, ex, ey;
        logic [31:0] z, oz, ez;
        int lat, rl;
        @(negedge clk);
        in_x[1] = {$urandom, $urandom};
        in_y[1] = {$urandom, $urandom};
        in_z[1] = 32'h00800000;
        in_valid[1] = 1'b1;
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2 arst = 1'b1;
        #1;
        n_tests++;
        if (out_x[1] !== 64'd0 || out_y[1] !== 64'd0 || out_z[1] !== 32'd0 ||
            out_valid[1] !== 1'b0 || out_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset got x=%h y=%h z=%h vld=%b rdy=%b want 0 0 0 0 1",
                     out_x[1], out_y[1], out_z[1], out_valid[1], out_ready[1]);
        end
        @(negedge clk);
        arst = 1'b0;
        x = {$urandom, $urandom} >>> 4;
        y = {$urandom, $urandom} >>> 4;
        z = $urandom;
        model(6, x, y, z, ex, ey, ez);
        op(1, x, y, z, ox, oy, oz, lat, rl);
        n_tests++;
        if (ox !== ex || oy !== ey || oz !== ez || lat !== 6) begin
            n_fail++;
            $display("FAIL after_reset got x=%h y=%h z=%h lat=%0d want x=%h y=%h z=%h lat=6",
                     ox, oy, oz, lat, ex, ey, ez);
        end
    endtask

    task automatic test_saturation;
        logic [63:0] ox, oy, ey;
        logic [31:0] oz;
        int lat, rl;
`ifdef CORDIC_HYP_EXT_ROT_SAT_EN
        ey = 64'h7FFFFFFF_FFFFFFFF;
`else
        ey = 64'hDFFFFFFF_FFFFFFFF;
`endif
        op(0, 64'h7FFFFFFF_FFFFFFFF, 64'h7FFFFFFF_FFFFFFFF, 32'h01000000, ox, oy, oz, lat, rl);
        n_tests++;
        if (oy !== ey || ox !== ey) begin
            n_fail++;
            $display("FAIL saturation got x=%h y=%h want %h", ox, oy, ey);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0;
            in_ready[s] = 1'b1;
            in_x[s] = '0;
            in_y[s] = '0;
            in_z[s] = '0;
        end
        arst = 1'b1;
        #3;
        test_reset;
        @(negedge clk);
        arst = 1'b0;
        test_positive_z;
        test_negative_z;
        test_latency_rom;
        test_random;
        test_backpressure;
        test_reset_mid_iter;
        test_saturation;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cordic_hyp_ext_rot.md
# cordic_hyp_ext_rot

Rotation-mode range-extension stage for the hyperbolic CORDIC, used in the exponential (`cordic_exp`) datapath. It is the counterpart of the vectoring-mode extension used by the logarithm path. It applies the negative-index micro-rotations i = -(M-1) .. 0 to (x, y, z), steering by the sign of z. This drives z toward zero and widens the convergence range before the standard i ≥ 1 hyperbolic iterations. The block is iterative: one micro-rotation per clock, with a valid/ready handshake on both sides.

## Interface
- `WD`, default 32: base word length; x/y datapath is 2*WD bits signed.
- `M`, default 6: number of negative-index iterations, 1..6; indices run -(M-1) up to 0.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_arst` in 1: asynchronous, active-high reset.
- `i_valid` in 1: input sample valid.
- `o_ready` out 1: block can accept a sample.
- `i_x` in 2*WD: signed x; fixed-point format is shared with y and chosen by the user.
- `i_y` in 2*WD: signed y.
- `i_z` in 32: signed angle, Q8.24.
- `o_x` out 2*WD: extended x.
- `o_y` out 2*WD: extended y.
- `o_z` out 32: residual angle, Q8.24.
- `o_valid` out 1: result valid.
- `i_ready` in 1: downstream accepts result.

## Operation
- FSM with three states: IDLE, ITER, DONE.
  - IDLE: `o_ready`=1. When `i_valid`&&`o_ready` at an edge, capture `i_x`/`i_y`/`i_z`, load iteration index k = -(M-1), then go to ITER.
  - ITER: one micro-rotation per edge. If k==0 at this edge, go to DONE; else k<=k+1.
  - DONE: `o_valid`=1. If `i_ready`, go to IDLE.
- Micro-rotation at index k:
  - d = +1 if z[31]==0 (z ≥ 0, zero included); d = -1 otherwise.
  - x' = x + d·(y - (y >>> (2-k)))
  - y' = y + d·(x - (x >>> (2-k)))
  - z' = z - d·atanh(1 - 2^(k-2))
  - All three updates use the pre-update values (simultaneous). Shifts are arithmetic.
- atanh ROM, indexed combinationally by k (Q8.24):
  - -5: 02C54820
  - -4: 026C0E53
  - -3: 0212523D
  - -2: 01B78CD5
  - -1: 015AA163
  - 0: 00F91395
- Width rules:
  - x/y sums are computed in 2*WD bits; wrap-around unless `CORDIC_HYP_EXT_ROT_SAT_EN` is defined.
  - z is 32-bit two's-complement and always wraps.
- `o_x`/`o_y`/`o_z` are the working registers. They change only in ITER and are stable from DONE entry until the handshake completes.
- `i_valid` is ignored outside IDLE; there is no buffering and no overlap.

## Timing
- Reset (async, immediate): state=IDLE, k=0, x/y/z regs=0, so `o_x`=`o_y`=`o_z`=0, `o_valid`=0, `o_ready`=1.
- Latency: if the sample is accepted at edge n, `o_valid` rises after edge n+M and remains high until an edge with `i_ready`=1.
- `i_ready` already high on DONE entry: result is consumed on the first DONE edge. Throughput is one sample per M+2 cycles.
- `o_ready` deasserts on the accept edge and reasserts on the edge that leaves DONE. An input and an output handshake never occur in the same cycle.
- Reset asserted mid-ITER or mid-DONE: the operation is aborted with no output. After reset, the next accepted sample runs a full M iterations.

## Configuration
- `CORDIC_HYP_EXT_ROT_SAT_EN` defined:
  - each x'/y' is computed with one guard bit;
  - on signed overflow the result saturates to 0x7FF…F or 0x800…0 (2*WD bits);
  - z still wraps.
- Not defined: plain 2*WD-bit two's-complement wrap and no guard logic.

## Test plan
All values use M=1, WD=32 and x/y in Q32.32 unless stated otherwise.
- **Positive z:** x=0x00000001_00000000, y=0, z=0x01000000.
  - Expect o_x=0x00000001_00000000, o_y=0x00000000_C0000000, o_z=0x0006EC6B.
  - `o_valid` rises 1 cycle after the accept edge.
- **Negative z:** same x/y, z=0xFF000000.
  - Expect o_y=0xFFFFFFFF_40000000, o_x unchanged, o_z=0xFFF91395.
- **Latency and ROM coverage:** M=6, z=0 (forces d=+1 at k=-5).
  - `o_valid` rises exactly 6 cycles after accept.
  - `o_ready` stays low for 7 cycles.
  - z sequence matches the ROM values, compared against a bit-exact reference model.
- **Backpressure:** hold `i_ready`=0 for 5 cycles in DONE while toggling `i_valid` and input data.
  - Outputs stay stable and `o_ready` stays 0.
  - The result is consumed on the first `i_ready`=1 edge, and the next sample is accepted in IDLE afterwards.
- **Reset mid-ITER:** M=6, assert `i_arst` at iteration 3.
  - All outputs go to 0, `o_valid`=0, `o_ready`=1 immediately.
  - A following sample yields the correct result.
- **Saturation:** x=y=0x7FFFFFFF_FFFFFFFF, z=0x01000000.
  - With the macro defined: o_y=0x7FFFFFFF_FFFFFFFF.
  - Without the macro: o_y equals the wrapped 64-bit sum, which is negative.
